missing_duplicated_word_lanes: RTL
==================================

Name: missing_duplicated_word_lanes

Overview:
- Parametrised successor to the single-lane missing/duplicated word finder.
- Holds N words of W bits in a write-port state array and scans L entries per cycle.
- Builds per-value occurrence state and reports, per mode, the lowest value that is odd-count, missing or duplicated, plus the count of qualifying values.
- Sits behind a control agent: the agent loads state, pulses start, and waits for a one-cycle valid.

Parameters:
- W, 5: word width; value space is 2**W.
- N, 17: number of state entries.
- L, 2: lanes (entries scanned) per cycle; 1 <= L <= N.
- V, 2**W: missing mode considers only values 0..V-1; V <= 2**W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- state_upt  in  1  write strobe for the state array.
- state_id  in  $clog2(N)  write index; must be < N.
- state_dat  in  W  write data.
- cntrl_start  in  1  start scan; sampled only when idle.
- cntrl_mode  in  2  sampled with start: 0 odd-count, 1 missing, 2 duplicated, 3 reserved (treated as 0).
- cntrl_busy_r  out  1  scan in progress.
- cntrl_vld_r  out  1  one-cycle pulse when the result is updated.
- cntrl_found_r  out  1  at least one value qualified.
- cntrl_dat_r  out  W  lowest qualifying value; 0 if none.
- cntrl_cnt_r  out  $clog2(2**W+1)  number of qualifying values.

Behaviour:
- Reset:
  - Single clock clk; reset rst is asynchronous, active-high.
  - All outputs reset to 0; FSM resets to IDLE.
  - The state array is not reset.
- Per-value flags, each 2**W bits: seen_r, multi_r, par_r. All cleared in the cycle start is accepted.
- FSM IDLE -> SCAN -> RESOLVE -> IDLE.
  - IDLE: if start is sampled at edge 0, latch mode, clear flags and beat_r, go to SCAN. busy_r=1 from cycle 1. vld_r drops when start is accepted.
  - SCAN: B = ceil(N/L) beats.
    - Beat b reads entries b*L+k for k in 0..L-1, combinationally from current array contents.
    - Lanes with index >= N are masked; the last beat is partial when N%L != 0.
    - For each value v, c = number of unmasked lanes equal to v (0..L):
      - par ^= c[0]
      - multi |= (seen & c>0) | (c>=2)
      - seen |= (c>0)
    - Several lanes with the same value in one beat must be counted correctly.
    - After beat B-1, go to RESOLVE.
  - RESOLVE (one cycle):
    - qualify vector by mode: par (odd), ~seen masked to bits < V (missing), multi (duplicated).
    - dat = lowest set index; cnt = popcount; found = |qualify.
    - Register all three, pulse vld_r next cycle, busy_r -> 0, return to IDLE.
- Latency: start at edge 0 gives busy_r high for cycles 1..B+1 and vld_r=1 in cycle B+2. Back-to-back start is accepted in cycle B+2.
- Results hold until the next RESOLVE. found/dat/cnt change only together with vld_r.
- cntrl_start while busy: ignored; no restart, no error.
- state_upt during a scan:
  - The write is performed.
  - It is visible to the scan only if the entry is read in a later beat.
  - The result is consistent with exactly that visibility.
- Simultaneous state_upt and cntrl_start: the write lands; beat 0 reads at cycle 1, so it sees the write.
- rst mid-scan: busy_r, vld_r, found, dat and cnt clear asynchronously; no vld pulse is produced; the array is unchanged.
- Width rules:
  - beat_r is $clog2(B+1) bits.
  - Lane index compare against N is done at $clog2(N)+1 bits to avoid wrap.
  - cnt saturates naturally; max is 2**W and fits the port width.

Optional Feature:
- Macro: MISSING_DUPLICATED_WORD_LANES_ABORT_EN.
- Defined:
  - Adds input cntrl_abort (1 bit).
  - Abort sampled high while busy returns the FSM to IDLE at that edge; busy_r=0 next cycle.
  - No vld pulse; previous results are retained.
  - Abort while idle has no effect; abort and start together while idle: start wins.
- Undefined: no port and no abort logic; the scan always runs to completion.

Test Plan:
1. W=5,N=17,L=2; load entries 0..15 = 0..15, entry16 = 7; mode=2, start -> busy 10 cycles, vld cycle 11, found=1, dat=7, cnt=1.
2. Same contents, mode=1, V=32 -> found=1, dat=16, cnt=16; rerun with V=16 -> found=0, dat=0, cnt=0.
3. Entries = 0,0,1,1,...,7,7 (same-value lane pairs per beat), entry16 = 9; mode=0 -> dat=9, cnt=1. Same contents, mode=2 -> dat=0, cnt=8 (checks in-beat duplicate counting and masked lane 1 of the last beat).
4. All 17 entries = 3, mode=0 -> dat=3, cnt=1. Same contents, mode=1 -> dat=0, cnt=31.
5. Start during busy at cycle 4 -> ignored, single vld at cycle 11. rst asserted at cycle 5 -> all outputs 0 immediately, no vld; a new start completes with the correct result.
6. ABORT_EN defined: abort at cycle 3 -> busy_r=0 at cycle 4, no vld, prior dat/cnt unchanged. State write to entry 16 at cycle 4 of a scan -> visible in the result (read in beat 8).

Source files
------------

// File: rtl/missing_duplicated_word_lanes.sv
// ---------------------------------------------------------------------------
// missing_duplicated_word_lanes
//
// Purpose:
//    Holds N words of W bits in a write-port state array. On a start request
//    it scans the array L entries per cycle and builds per-value occurrence
//    flags (seen, seen-more-than-once, odd parity). One cycle after the scan
//    it reports the lowest value that qualifies in the requested mode (odd
//    count, missing, duplicated), how many values qualify, and a one-cycle
//    valid pulse.
//
// Ports:
//    clk            clock
//    rst            asynchronous active-high reset
//    state_upt      write strobe for the state array
//    state_id       write index (< N)
//    state_dat      write data
//    cntrl_start    start a scan (sampled only when idle)
//    cntrl_mode     0 odd-count, 1 missing, 2 duplicated, 3 treated as 0
//    cntrl_abort    (only with MISSING_DUPLICATED_WORD_LANES_ABORT_EN)
//                   abandon the current scan, keep previous results
//    cntrl_busy_r   scan in progress
//    cntrl_vld_r    one-cycle pulse when results are updated
//    cntrl_found_r  at least one value qualified
//    cntrl_dat_r    lowest qualifying value, 0 if none
//    cntrl_cnt_r    number of qualifying values
//
// Optional feature macro: MISSING_DUPLICATED_WORD_LANES_ABORT_EN
// ---------------------------------------------------------------------------
module missing_duplicated_word_lanes #(
   parameter int W = 5,
   parameter int N = 17,
   parameter int L = 2,
   parameter int V = 2**W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        state_upt,
   input  logic [$clog2(N)-1:0]        state_id,
   input  logic [W-1:0]                state_dat,
   input  logic                        cntrl_start,
   input  logic [1:0]                  cntrl_mode,
`ifdef MISSING_DUPLICATED_WORD_LANES_ABORT_EN
   input  logic                        cntrl_abort,
`endif
   output logic                        cntrl_busy_r,
   output logic                        cntrl_vld_r,
   output logic                        cntrl_found_r,
   output logic [W-1:0]                cntrl_dat_r,
   output logic [$clog2(2**W+1)-1:0]   cntrl_cnt_r
);

   localparam int NV  = 2**W;
   localparam int B   = (N + L - 1) / L;
   localparam int BW  = $clog2(B + 1);
   localparam int IDW = $clog2(N);
   localparam int IW  = $clog2(N) + 1;
   localparam int CW  = $clog2(2**W + 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      RESOLVE
   } scanState_e;

   scanState_e        state_q;
   logic [BW-1:0]     beat_q;
   logic [1:0]        mode_q;
   logic [NV-1:0]     seen_q, multi_q, par_q;
   logic [NV-1:0]     seen_d, multi_d, par_d;
   logic              busy_q, vld_q, found_q;
   logic [W-1:0]      dat_q;
   logic [CW-1:0]     cnt_q;

   logic [W-1:0]      mem_q [N];

   logic [IW-1:0]     laneIdx [L];
   logic              laneVld [L];
   logic [W-1:0]      laneDat [L];

   logic [NV-1:0]     hitVec, twoVec, oddVec;
   logic [NV-1:0]     vMask, qualify;
   logic [W-1:0]      lowestVal;
   logic [CW-1:0]     popCount;

   // The state array is a plain write port with no reset; its contents
   // survive reset so the agent does not need to reload after recovery.
   always_ff @(posedge clk) begin
      if (state_upt) begin
         mem_q[state_id] <= state_dat;
      end
   end

   // Lane addressing for the current beat. The index is kept one bit wider
   // than the array index so the last, partial beat cannot wrap around and
   // alias a low entry; lanes past the end are masked and read as zero.
   always_comb begin
      for (int k = 0; k < L; k++) begin
         laneIdx[k] = IW'(beat_q) * IW'(L) + IW'(k);
         laneVld[k] = (laneIdx[k] < IW'(N));
         laneDat[k] = laneVld[k] ? mem_q[laneIdx[k][IDW-1:0]] : '0;
      end
   end

   // Per-value occurrence summary for this beat. Walking the lanes in order,
   // a value matching a second time sets its "two or more" bit, so several
   // lanes carrying the same value in one beat are counted correctly. The
   // odd bit toggles per match, giving the low bit of the lane count.
   always_comb begin
      hitVec = '0;
      twoVec = '0;
      oddVec = '0;
      for (int v = 0; v < NV; v++) begin
         for (int k = 0; k < L; k++) begin
            if (laneVld[k] && (laneDat[k] == W'(v))) begin
               twoVec[v] = twoVec[v] | hitVec[v];
               hitVec[v] = 1'b1;
               oddVec[v] = ~oddVec[v];
            end
         end
      end
      seen_d  = seen_q | hitVec;
      multi_d = multi_q | (seen_q & hitVec) | twoVec;
      par_d   = par_q ^ oddVec;
   end

   // Result selection from the finished flags: pick the qualifying vector
   // for the latched mode, then find its lowest set bit and its popcount.
   // Missing mode only looks at values below V.
   always_comb begin
      vMask = '0;
      for (int v = 0; v < NV; v++) begin
         vMask[v] = (v < V);
      end
      case (mode_q)
         2'd1:    qualify = ~seen_q & vMask;
         2'd2:    qualify = multi_q;
         default: qualify = par_q;
      endcase
      lowestVal = '0;
      for (int v = NV - 1; v >= 0; v--) begin
         if (qualify[v]) begin
            lowestVal = W'(v);
         end
      end
      popCount = '0;
      for (int v = 0; v < NV; v++) begin
         popCount = popCount + CW'(qualify[v]);
      end
   end

   // Control FSM with registered outputs. Accepting a start clears the
   // flags and beat counter; each SCAN cycle folds one beat into the flags;
   // RESOLVE captures the result and pulses valid as it returns to IDLE.
   // Starts arriving while busy are simply not looked at.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         mode_q  <= '0;
         seen_q  <= '0;
         multi_q <= '0;
         par_q   <= '0;
         busy_q  <= 1'b0;
         vld_q   <= 1'b0;
         found_q <= 1'b0;
         dat_q   <= '0;
         cnt_q   <= '0;
      end else begin
         vld_q <= 1'b0;
`ifdef MISSING_DUPLICATED_WORD_LANES_ABORT_EN
         if ((state_q != IDLE) && cntrl_abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else
`endif
         begin
            case (state_q)
               IDLE: begin
                  if (cntrl_start) begin
                     mode_q  <= cntrl_mode;
                     seen_q  <= '0;
                     multi_q <= '0;
                     par_q   <= '0;
                     beat_q  <= '0;
                     busy_q  <= 1'b1;
                     state_q <= SCAN;
                  end
               end
               SCAN: begin
                  seen_q  <= seen_d;
                  multi_q <= multi_d;
                  par_q   <= par_d;
                  if (beat_q == BW'(B - 1)) begin
                     state_q <= RESOLVE;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
               RESOLVE: begin
                  found_q <= |qualify;
                  dat_q   <= lowestVal;
                  cnt_q   <= popCount;
                  vld_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cntrl_busy_r  = busy_q;
   assign cntrl_vld_r   = vld_q;
   assign cntrl_found_r = found_q;
   assign cntrl_dat_r   = dat_q;
   assign cntrl_cnt_r   = cnt_q;

endmodule
